// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the IF stage and its IF->ID interface.
// Build option: define IF_FETCH_ADEL_EN to add fetch address-error detection.
package if_fetch_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STALL_W = 6;
    localparam int unsigned STALL_PC = 0;
    localparam int unsigned STALL_ID = 1;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [XLEN-1:0] IF_RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic            br_e;
        logic [XLEN-1:0] br_addr;
    } br_bus_t;

    localparam int unsigned BR_WD = $bits(br_bus_t);

`ifdef IF_FETCH_ADEL_EN
    typedef struct packed {
        logic            adel;
        logic            ce;
        logic [XLEN-1:0] pc;
    } if_to_id_t;
`else
    typedef struct packed {
        logic            ce;
        logic [XLEN-1:0] pc;
    } if_to_id_t;
`endif

    localparam int unsigned IF_TO_ID_WD = $bits(if_to_id_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_inst_hold.sv
// Holds the fetched word while ID is stalled and selects the word presented to ID.
module if_inst_hold
    import if_fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clr,
    input  logic            out_en,
    input  logic            nop,
    input  logic [XLEN-1:0] inst_sram_rdata,
    output logic [XLEN-1:0] inst_to_id
);

    logic [XLEN-1:0] hold_word_q, hold_word_d;
    logic            hold_valid_q, hold_valid_d;

    always_comb begin : hold_next
        hold_word_d  = hold_word_q;
        hold_valid_d = hold_valid_q;
        if (clr) begin
            hold_valid_d = 1'b0;
        end else if (load) begin
            hold_word_d  = inst_sram_rdata;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_word_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_word_q  <= hold_word_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Silent until the first fetch after reset; a misaligned fetch becomes a NOP.
    always_comb begin : out_mux
        inst_to_id = '0;
        if (out_en && !nop) begin
            inst_to_id = hold_valid_q ? hold_word_q : inst_sram_rdata;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC, drives the instruction SRAM, feeds the IF->ID bus.
// Build option: IF_FETCH_ADEL_EN adds the adel_excp port and its bus bit.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [XLEN-1:0]        new_pc,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [XLEN-1:0]        inst_to_id,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [XLEN-1:0]        inst_sram_addr,
    output logic [XLEN-1:0]        inst_sram_wdata,
    input  logic [XLEN-1:0]        inst_sram_rdata
`ifdef IF_FETCH_ADEL_EN
    ,
    output logic                   adel_excp
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] br_tgt_q, br_tgt_d;
    logic            br_pend_q, br_pend_d;
    logic            ce_q, ce_d;
    logic            buf_load_c, buf_clr_c;
    logic            adel_c;
    br_bus_t         br_c;
    if_to_id_t       id_bus_c;
    logic            unused_c;

    assign br_c     = br_bus_t'(br_bus);
    assign unused_c = ^stall[STALL_W-1:2];

    // Next PC: flush, then PC stall, then branch (live or pending), then sequential.
    always_comb begin : next_pc
        pc_d      = pc_q;
        br_tgt_d  = br_tgt_q;
        br_pend_d = br_pend_q;
        if (flush) begin
            pc_d      = new_pc;
            br_pend_d = 1'b0;
        end else if (stall[STALL_PC] == STOP) begin
            if (br_c.br_e) begin
                br_pend_d = 1'b1;
                br_tgt_d  = br_c.br_addr;
            end
        end else if (br_c.br_e) begin
            pc_d      = br_c.br_addr;
            br_pend_d = 1'b0;
        end else if (br_pend_q) begin
            pc_d      = br_tgt_q;
            br_pend_d = 1'b0;
        end else begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_comb begin : fsm_next
        state_d    = state_q;
        ce_d       = ce_q;
        buf_load_c = 1'b0;
        buf_clr_c  = 1'b0;
        if (flush) begin
            state_d   = FETCH;
            ce_d      = 1'b1;
            buf_clr_c = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    ce_d    = 1'b1;
                end
                FETCH: begin
                    if (stall[STALL_ID] == STOP) begin
                        state_d    = HOLD;
                        buf_load_c = 1'b1;
                    end
                end
                HOLD: begin
                    if (stall[STALL_ID] == NO_STOP) begin
                        state_d   = FETCH;
                        buf_clr_c = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC - XLEN'(4);
            br_tgt_q  <= '0;
            br_pend_q <= 1'b0;
            ce_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            br_tgt_q  <= br_tgt_d;
            br_pend_q <= br_pend_d;
            ce_q      <= ce_d;
        end
    end

`ifdef IF_FETCH_ADEL_EN
    assign adel_c    = ce_q & (|pc_q[1:0]);
    assign adel_excp = adel_c;
`else
    assign adel_c = 1'b0;
`endif

    // The bus reads all-zero until the first fetch so ID sees nothing during reset.
    always_comb begin : id_bus
        id_bus_c = '0;
        if (ce_q) begin
            id_bus_c.ce = 1'b1;
            id_bus_c.pc = pc_q;
`ifdef IF_FETCH_ADEL_EN
            id_bus_c.adel = adel_c;
`endif
        end
    end

    assign if_to_id_bus    = IF_TO_ID_WD'(id_bus_c);
    assign inst_sram_en    = ce_q & ~adel_c;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wdata = '0;

    if_inst_hold u_inst_hold (
        .clk             (clk),
        .rst             (rst),
        .load            (buf_load_c),
        .clr             (buf_clr_c),
        .out_en          (ce_q),
        .nop             (adel_c),
        .inst_sram_rdata (inst_sram_rdata),
        .inst_to_id      (inst_to_id)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; the SRAM model returns ~addr one cycle late.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [31:0]            new_pc;
    logic [STALL_W-1:0]     stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic [31:0]            inst_to_id;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic [31:0]            inst_sram_rdata = 32'h0;
`ifdef IF_FETCH_ADEL_EN
    logic                   adel_excp;
`endif

    logic        force_en  = 1'b0;
    logic [31:0] force_val = 32'h0;
    int          n_chk = 0;
    int          n_err = 0;

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .new_pc          (new_pc),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_to_id      (inst_to_id),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
`ifdef IF_FETCH_ADEL_EN
        ,
        .adel_excp       (adel_excp)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        inst_sram_rdata <= force_en ? force_val : ~inst_sram_addr;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] bus(input logic ce, input logic [31:0] pc);
        logic [63:0] b;
        b = {31'b0, ce, pc};
`ifdef IF_FETCH_ADEL_EN
        b[33] = ce & (pc[1:0] != 2'b00);
`endif
        return b;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; new_pc = '0; stall = '0; br_bus = '0;
        #2 rst = 1'b0;
        step(); step();
        chk("rst_en",   64'(inst_sram_en), 64'h0);
        chk("rst_bus",  64'(if_to_id_bus), 64'h0);
        chk("rst_inst", 64'(inst_to_id),   64'h0);
        chk("rst_addr", 64'(inst_sram_addr), 64'hBFBF_FFFC);

        // Reset release: first cycle idle, then sequential fetch
        rst = 1'b1;
        #1;
        chk("idle_en", 64'(inst_sram_en), 64'h0);
        step();
        chk("f0_addr", 64'(inst_sram_addr), 64'hBFC0_0000);
        chk("f0_en",   64'(inst_sram_en),   64'h1);
        chk("f0_bus",  64'(if_to_id_bus),   bus(1'b1, 32'hBFC0_0000));
        step();
        chk("f1_addr", 64'(inst_sram_addr), 64'hBFC0_0004);
        chk("f1_inst", 64'(inst_to_id),     64'h403F_FFFF);
        step();
        chk("f2_addr", 64'(inst_sram_addr), 64'hBFC0_0008);
        chk("f2_inst", 64'(inst_to_id),     64'h403F_FFFB);
        chk("wen",     64'(inst_sram_wen),  64'h0);
        chk("wdata",   64'(inst_sram_wdata), 64'h0);

        // Branch arriving while the delay slot is fetched
        br_bus = {1'b1, 32'hBFC0_0100};
        #1;
        chk("ds_bus", 64'(if_to_id_bus), bus(1'b1, 32'hBFC0_0008));
        step();
        br_bus = '0;
        chk("br_addr", 64'(inst_sram_addr), 64'hBFC0_0100);
        chk("ds_inst", 64'(inst_to_id),     64'h403F_FFF7);
        force_en = 1'b1; force_val = 32'h2401_0005;
        step();
        chk("br_seq", 64'(inst_sram_addr), 64'hBFC0_0104);
        chk("st_in",  64'(inst_to_id),     64'h2401_0005);

        // Full stall for 3 cycles; SRAM word changes underneath
        stall = 6'b000011;
        force_val = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_addr", 64'(inst_sram_addr), 64'hBFC0_0104);
            chk("st_inst", 64'(inst_to_id),     64'h2401_0005);
        end
        stall = '0;
        force_en = 1'b0;
        step();
        chk("rel_addr", 64'(inst_sram_addr), 64'hBFC0_0108);
        chk("rel_inst", 64'(inst_to_id),     64'h403F_FEFB);

        // Branch during PC stall is latched and taken after release
        stall = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0200};
        step();
        br_bus = '0;
        chk("bp_hold0", 64'(inst_sram_addr), 64'hBFC0_0108);
        step();
        chk("bp_hold1", 64'(inst_sram_addr), 64'hBFC0_0108);
        stall = '0;
        step();
        chk("bp_tgt", 64'(inst_sram_addr), 64'hBFC0_0200);

        // Flush beats stall, live branch and a pending branch
        stall = 6'b000011;
        br_bus = {1'b1, 32'hBFC0_0300};
        step();
        chk("fl_pre", 64'(inst_sram_addr), 64'hBFC0_0200);
        flush = 1'b1; new_pc = 32'hBFC0_0380;
        step();
        flush = 1'b0; br_bus = '0; stall = '0;
        chk("fl_addr", 64'(inst_sram_addr), 64'hBFC0_0380);
        chk("fl_inst", 64'(inst_to_id),     64'h403F_FDFF);
        step();
        chk("fl_seq", 64'(inst_sram_addr), 64'hBFC0_0384);

        // Asynchronous reset in the middle of fetching
        #2 rst = 1'b0;
        #1;
        chk("ar_en",   64'(inst_sram_en),   64'h0);
        chk("ar_bus",  64'(if_to_id_bus),   64'h0);
        chk("ar_inst", 64'(inst_to_id),     64'h0);
        chk("ar_addr", 64'(inst_sram_addr), 64'hBFBF_FFFC);
        step();
        rst = 1'b1;
        step();
        chk("ar_rf", 64'(inst_sram_addr), 64'hBFC0_0000);

        // Misaligned flush target
        flush = 1'b1; new_pc = 32'hBFC0_0382;
        step();
        flush = 1'b0;
        chk("mis_addr", 64'(inst_sram_addr), 64'hBFC0_0382);
        chk("mis_bus",  64'(if_to_id_bus),   bus(1'b1, 32'hBFC0_0382));
`ifdef IF_FETCH_ADEL_EN
        chk("mis_adel", 64'(adel_excp),    64'h1);
        chk("mis_en",   64'(inst_sram_en), 64'h0);
        chk("mis_inst", 64'(inst_to_id),   64'h0);
`else
        chk("mis_en",   64'(inst_sram_en), 64'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
